// File: rtl/svm_coef_loader.sv
// svm_coef_loader: streams a bias plus N_COEF*N_WORD packed coefficients into the SVM coefficient RAM.
// Define COEF_READBACK_EN to re-read the RAM after loading and flag a checksum mismatch on err.
module svm_coef_loader #(
    parameter int COEF_W = 12,
    parameter int N_COEF = 105,
    parameter int N_WORD = 36,
    parameter int ADDR_W = 6,
    localparam int RAM_DW = COEF_W * N_COEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [COEF_W-1:0] s_data,
    output logic [ADDR_W-1:0] addr_a,
    output logic              write_en,
    output logic [RAM_DW-1:0] o_ram_data,
    input  logic [RAM_DW-1:0] o_data_a,
    output logic [COEF_W-1:0] bias,
    output logic              b_load,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WC_W = (N_WORD > 1) ? $clog2(N_WORD) : 1;
    localparam int CC_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(N_WORD - 1);
    localparam logic [CC_W-1:0]   LAST_COEF = CC_W'(N_COEF - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORD - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_BIAS    = 3'd1;
    localparam logic [2:0] S_FILL    = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
`ifdef COEF_READBACK_EN
    localparam logic [2:0] S_RB_ADDR = 3'd4;
    localparam logic [2:0] S_RB_CMP  = 3'd5;
`endif
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]      state;
    logic [WC_W-1:0] word_cnt;
    logic [CC_W-1:0] coef_cnt;
    logic [15:0]     checksum;

    assign s_ready  = (state == S_BIAS) || (state == S_FILL);
    assign write_en = (state == S_WRITE);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    // s_ready is high in BIAS and FILL, so s_valid alone marks a transfer there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            word_cnt   <= '0;
            coef_cnt   <= '0;
            checksum   <= '0;
            addr_a     <= '0;
            // NOTE: the wide packing register is reset too, so outputs are clean right after rst.
            o_ram_data <= '0;
            bias       <= '0;
            b_load     <= 1'b0;
        end else begin
            b_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_BIAS;
                        word_cnt <= '0;
                        coef_cnt <= '0;
                        checksum <= '0;
                    end
                end
                S_BIAS: begin
                    if (s_valid) begin
                        bias   <= s_data;
                        b_load <= 1'b1;
                        state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (s_valid) begin
                        o_ram_data[COEF_W*int'(coef_cnt) +: COEF_W] <= s_data;
                        checksum <= checksum + 16'(s_data);
                        if (coef_cnt == LAST_COEF) begin
                            coef_cnt <= '0;
                            addr_a   <= ADDR_W'(word_cnt);
                            state    <= S_WRITE;
                        end else begin
                            coef_cnt <= coef_cnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (word_cnt == LAST_WORD) begin
`ifdef COEF_READBACK_EN
                        addr_a <= '0;
                        state  <= S_RB_ADDR;
`else
                        state  <= S_DONE;
`endif
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        state    <= S_FILL;
                    end
                end
`ifdef COEF_READBACK_EN
                S_RB_ADDR: begin
                    if (addr_a == LAST_ADDR) begin
                        state <= S_RB_CMP;
                    end else begin
                        addr_a <= addr_a + 1'b1;
                    end
                end
                S_RB_CMP: state <= S_DONE;
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef COEF_READBACK_EN
    logic [15:0] rb_sum;
    logic [15:0] rd_sum;
    logic        rd_pend;

    function automatic logic [15:0] word_sum(input logic [RAM_DW-1:0] word);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < N_COEF; i++) begin
            acc = acc + 16'(word[COEF_W*i +: COEF_W]);
        end
        return acc;
    endfunction

    assign rd_sum = word_sum(o_data_a);

    // rd_pend marks the cycle where o_data_a answers the address issued one cycle earlier.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_sum  <= '0;
            rd_pend <= 1'b0;
            err     <= 1'b0;
        end else begin
            rd_pend <= (state == S_RB_ADDR);
            if (state == S_IDLE && start) begin
                rb_sum <= '0;
                err    <= 1'b0;
            end else if (rd_pend) begin
                rb_sum <= rb_sum + rd_sum;
            end
            if (state == S_RB_CMP && (rb_sum + rd_sum) != checksum) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{o_data_a, checksum};
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_svm_coef_loader.sv
// Directed/randomised bench for svm_coef_loader with a behavioural RAM and coefficient model.
// Define COEF_READBACK_EN for both files to exercise the readback/err path.
module tb_svm_coef_loader;

    localparam int COEF_W  = 12;
    localparam int N_COEF  = 105;
    localparam int N_WORD  = 36;
    localparam int ADDR_W  = 6;
    localparam int RAM_DW  = COEF_W * N_COEF;
    localparam int N_BEATS = N_COEF * N_WORD;
`ifdef COEF_READBACK_EN
    localparam int EXP_LAT = 1 + N_WORD * (N_COEF + 1) + N_WORD + 1;
    localparam bit RB_ON   = 1'b1;
`else
    localparam int EXP_LAT = 1 + N_WORD * (N_COEF + 1);
    localparam bit RB_ON   = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [COEF_W-1:0] s_data;
    logic [ADDR_W-1:0] addr_a;
    logic              write_en;
    logic [RAM_DW-1:0] o_ram_data;
    logic [RAM_DW-1:0] o_data_a;
    logic [COEF_W-1:0] bias;
    logic              b_load;
    logic              busy;
    logic              done;
    logic              err;

    svm_coef_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .addr_a     (addr_a),
        .write_en   (write_en),
        .o_ram_data (o_ram_data),
        .o_data_a   (o_data_a),
        .bias       (bias),
        .b_load     (b_load),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read, optional single-field corruption of word 7 on write.
    logic [RAM_DW-1:0] mem [64];
    logic [RAM_DW-1:0] corrupt_mask;
    bit                corrupt_en = 1'b0;

    always @(posedge clk) begin
        if (write_en) begin
            mem[addr_a] <= (corrupt_en && addr_a == 6'd7) ? (o_ram_data ^ corrupt_mask) : o_ram_data;
        end
        o_data_a <= mem[addr_a];
    end

    // Observation log, sampled on the falling edge.
    int                cyc = 0;
    int                wr_addr_q [$];
    logic [RAM_DW-1:0] wr_data_q [$];
    int                bload_cnt = 0;
    int                done_cnt  = 0;
    int                done_cyc  = 0;
    logic [COEF_W-1:0] bias_seen = '0;
    logic              err_seen  = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (write_en) begin
            wr_addr_q.push_back(int'(addr_a));
            wr_data_q.push_back(o_ram_data);
        end
        if (b_load) begin
            bload_cnt++;
            bias_seen = bias;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            err_seen = err;
        end
    end

    // Reference stream: coefficient i of the model, in stream order.
    logic [COEF_W-1:0] coefs [N_BEATS];
    int n_cmp = 0;
    int n_err = 0;
    int wr_base, bl_base, d_base, start_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":s_ready"},  32'(s_ready),  32'd0);
        check({tag, ":write_en"}, 32'(write_en), 32'd0);
        check({tag, ":b_load"},   32'(b_load),   32'd0);
        check({tag, ":busy"},     32'(busy),     32'd0);
        check({tag, ":done"},     32'(done),     32'd0);
        check({tag, ":err"},      32'(err),      32'd0);
        check({tag, ":addr_a"},   32'(addr_a),   32'd0);
        check({tag, ":bias"},     32'(bias),     32'd0);
        check({tag, ":ram_zero"}, 32'(o_ram_data === '0), 32'd1);
    endtask

    // Drives one load; abort_writes>0 stops streaming once that many words were written.
    task automatic do_load(input logic [COEF_W-1:0] b, input bit rnd, input int start_idx,
                           input int abort_writes);
        int  idx;
        int  budget;
        bit  xfer;
        wr_base = wr_addr_q.size();
        bl_base = bload_cnt;
        d_base  = done_cnt;
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_cleared",      32'(err),  32'd0);
        idx    = 0;
        budget = 0;
        while (idx <= N_BEATS && budget < 20000) begin
            if (abort_writes > 0 && (wr_addr_q.size() - wr_base) >= abort_writes) break;
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = (idx == 0) ? b : coefs[idx-1];
            start   = (idx == start_idx);
            xfer    = s_valid && s_ready;
            @(negedge clk);
            if (xfer) idx++;
            budget++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        if (abort_writes == 0) begin
            check("stream_finished", 32'(idx), 32'(N_BEATS + 1));
            budget = 0;
            while (done_cnt == d_base && budget < 300) begin
                @(negedge clk);
                budget++;
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic verify(input string name, input logic [COEF_W-1:0] b, input bit chk_lat,
                          input bit exp_err);
        int                nw;
        int                bad_addr;
        int                bad;
        int                first;
        logic [RAM_DW-1:0] wd;
        nw = wr_addr_q.size() - wr_base;
        check({name, ":writes"}, 32'(nw), 32'(N_WORD));
        bad_addr = 0;
        for (int w = 0; w < nw; w++) begin
            if (wr_addr_q[wr_base+w] != w) bad_addr++;
        end
        check({name, ":addr_seq"}, 32'(bad_addr), 32'd0);
        for (int w = 0; w < nw && w < N_WORD; w++) begin
            wd    = wr_data_q[wr_base+w];
            bad   = 0;
            first = -1;
            for (int k = 0; k < N_COEF; k++) begin
                if (wd[k*COEF_W +: COEF_W] !== coefs[w*N_COEF+k]) begin
                    bad++;
                    if (first < 0) first = k;
                end
            end
            n_cmp++;
            assert (bad == 0) else begin
                n_err++;
                $error("FAIL %s:word%0d: %0d fields differ, field %0d observed 0x%0h expected 0x%0h",
                       name, w, bad, first, wd[first*COEF_W +: COEF_W], coefs[w*N_COEF+first]);
            end
        end
        check({name, ":b_load_cnt"}, 32'(bload_cnt - bl_base), 32'd1);
        check({name, ":bias_at_load"}, 32'(bias_seen), 32'(b));
        check({name, ":bias_hold"}, 32'(bias), 32'(b));
        check({name, ":done_cnt"}, 32'(done_cnt - d_base), 32'd1);
        check({name, ":err_at_done"}, 32'(err_seen), 32'(exp_err));
        check({name, ":err_hold"}, 32'(err), 32'(exp_err));
        check({name, ":idle"}, 32'(busy), 32'd0);
        if (chk_lat) check({name, ":latency"}, 32'(done_cyc - start_cyc), 32'(EXP_LAT));
    endtask

    task automatic spot_index(input string name);
        logic [RAM_DW-1:0] wd;
        if (wr_addr_q.size() - wr_base >= N_WORD) begin
            wd = wr_data_q[wr_base];
            check({name, ":w0f0"}, 32'(wd[11:0]), 32'h000);
            check({name, ":w0f1"}, 32'(wd[23:12]), 32'h001);
            wd = wr_data_q[wr_base+35];
            check({name, ":w35f104"}, 32'(wd[104*COEF_W +: COEF_W]), 32'hEC3);
        end else begin
            check({name, ":spot_words"}, 32'(wr_addr_q.size() - wr_base), 32'(N_WORD));
        end
    endtask

    initial begin
        logic [COEF_W-1:0] b;
        corrupt_mask = '0;
        corrupt_mask[3*COEF_W +: COEF_W] = 12'h800;
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // All-ones model, stream held valid.
        for (int i = 0; i < N_BEATS; i++) coefs[i] = 12'h001;
        do_load(12'h123, 1'b0, -1, 0);
        verify("ones", 12'h123, 1'b1, 1'b0);

        // Index pattern, held valid, then with random 50% stalls.
        for (int i = 0; i < N_BEATS; i++) coefs[i] = 12'(i % 4096);
        b = 12'($urandom);
        do_load(b, 1'b0, -1, 0);
        verify("index", b, 1'b1, 1'b0);
        spot_index("index");
        b = 12'($urandom);
        do_load(b, 1'b1, -1, 0);
        verify("index_stall", b, 1'b0, 1'b0);
        spot_index("index_stall");

        // Random model with a stray start pulse mid-FILL.
        for (int i = 0; i < N_BEATS; i++) coefs[i] = 12'($urandom);
        b = 12'($urandom);
        do_load(b, 1'b0, 500, 0);
        verify("start_ignored", b, 1'b1, 1'b0);

        // Reset after word 10 is written, then a full reload.
        for (int i = 0; i < N_BEATS; i++) coefs[i] = 12'($urandom);
        do_load(12'h5A5, 1'b0, -1, 11);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("mid_reset");
        b = 12'($urandom);
        do_load(b, 1'b0, -1, 0);
        verify("reload", b, 1'b1, 1'b0);

        // Corrupted RAM word 7 (flags err only when readback is built), then a clean rerun.
        for (int i = 0; i < N_BEATS; i++) coefs[i] = 12'($urandom);
        corrupt_en = 1'b1;
        b = 12'($urandom);
        do_load(b, 1'b1, -1, 0);
        verify("corrupt", b, 1'b0, RB_ON);
        corrupt_en = 1'b0;
        do_load(b, 1'b0, -1, 0);
        verify("clean", b, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
